// File: rtl/serial_paralelo_alineador_if.sv
// Serial link bundle between the serializer-side driver and the byte aligner.
// SERIAL_PARALELO_BYTE_CNT_EN adds the delivered-byte counter to the bundle.
interface serial_paralelo_alineador_if;
  logic        serial_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        byte_strobe;
  logic        active;
  logic        idle_out;
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  modport master (
    output serial_in,
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
    input  byte_cnt,
`endif
    input  data_out, valid_out, byte_strobe, active, idle_out
  );

  modport slave (
    input  serial_in,
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
    output byte_cnt,
`endif
    output data_out, valid_out, byte_strobe, active, idle_out
  );
endinterface

// File: rtl/serial_paralelo_alineador.sv
// RX deserializer: hunts for the COM comma at any bit offset, locks after BC_LOCK aligned commas,
// then emits one byte every 8 bit clocks. Optional byte counter: SERIAL_PARALELO_BYTE_CNT_EN.
module serial_paralelo_alineador #(
  parameter logic [7:0]  COM     = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic                          clk_32f,
  input  logic                          reset,
  serial_paralelo_alineador_if.slave    lnk
);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  localparam logic [3:0] LP_BC_LOCK = 4'(BC_LOCK);

  state_t      r_state,   w_state_nxt;
  logic [7:0]  r_sr;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]  r_bc_cnt,  w_bc_cnt_nxt;
  logic [7:0]  r_data,    w_data_nxt;
  logic        r_valid,   w_valid_nxt;
  logic        r_strobe,  w_strobe_nxt;
  logic        r_active,  w_active_nxt;
  logic        r_idle,    w_idle_nxt;
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
  logic [15:0] r_byte_cnt, w_byte_cnt_nxt;
`endif

  logic w_is_com;
  logic w_boundary;

  // Comparisons look at the byte completed by the previous edge, before this edge's shift.
  assign w_is_com   = (r_sr == COM);
  assign w_boundary = (r_bit_cnt == 3'd7) && (r_state != SEARCH);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    w_bc_cnt_nxt  = r_bc_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_strobe_nxt  = 1'b0;
    w_active_nxt  = r_active;
    w_idle_nxt    = r_idle;
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
    w_byte_cnt_nxt = r_byte_cnt;
`endif

    unique case (r_state)
      SEARCH: begin
        if (w_is_com) begin
          w_bit_cnt_nxt = 3'd0;
          w_bc_cnt_nxt  = 4'd1;
          if (LP_BC_LOCK == 4'd1) begin
            w_state_nxt  = LOCKED;
            w_active_nxt = 1'b1;
          end else begin
            w_state_nxt  = SYNC;
          end
        end
      end

      SYNC: begin
        if (w_boundary) begin
          if (w_is_com) begin
            if (r_bc_cnt + 4'd1 >= LP_BC_LOCK) begin
              w_bc_cnt_nxt = LP_BC_LOCK;
              w_state_nxt  = LOCKED;
              w_active_nxt = 1'b1;
            end else begin
              w_bc_cnt_nxt = r_bc_cnt + 4'd1;
            end
          end else begin
            w_bc_cnt_nxt = 4'd0;
            w_state_nxt  = SEARCH;
          end
        end
      end

      LOCKED: begin
        // Lock is sticky: misaligned or comma-straddling data is passed through untouched.
        if (w_boundary) begin
          w_data_nxt   = r_sr;
          w_strobe_nxt = 1'b1;
          w_valid_nxt  = !w_is_com;
          w_idle_nxt   = w_is_com;
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
          if (!w_is_com) w_byte_cnt_nxt = r_byte_cnt + 16'd1;
`endif
        end
      end

      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state    <= SEARCH;
      r_sr       <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_bc_cnt   <= 4'd0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_strobe   <= 1'b0;
      r_active   <= 1'b0;
      r_idle     <= 1'b1;
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
      r_byte_cnt <= 16'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_state    <= w_state_nxt;
      r_sr       <= {r_sr[6:0], lnk.serial_in};
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_bc_cnt   <= w_bc_cnt_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_strobe   <= w_strobe_nxt;
      r_active   <= w_active_nxt;
      r_idle     <= w_idle_nxt;
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
      r_byte_cnt <= w_byte_cnt_nxt;
`endif
    end
  end

  assign lnk.data_out    = r_data;
  assign lnk.valid_out   = r_valid;
  assign lnk.byte_strobe = r_strobe;
  assign lnk.active      = r_active;
  assign lnk.idle_out    = r_idle;
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
  assign lnk.byte_cnt    = r_byte_cnt;
`endif

endmodule

// File: tb/tb_serial_paralelo_alineador.sv
// Directed bench for serial_paralelo_alineador: reset, alignment, SYNC abort, locked stream,
// async reset mid-byte, and the optional byte counter when SERIAL_PARALELO_BYTE_CNT_EN is set.
module tb_serial_paralelo_alineador;

  localparam logic [7:0] BC = 8'hBC;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       idle;
    int         cyc;
  } rec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   last_cyc;
  int   act_cyc;
  logic prev_act;
  int   strobe_cnt;
  rec_t recs [256];

  serial_paralelo_alineador_if vif ();

  serial_paralelo_alineador #(.COM(8'hBC), .BC_LOCK(4)) dut (
    .clk_32f (clk),
    .reset   (rst_n),
    .lnk     (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are observed on the falling edge, half a period after they change.
  always @(negedge clk) begin
    prev_act <= vif.active;
    if (vif.active === 1'b1 && prev_act !== 1'b1) act_cyc <= cyc;
    if (vif.byte_strobe === 1'b1) begin
      recs[strobe_cnt % 256] <= '{vif.data_out, vif.valid_out, vif.idle_out, cyc};
      strobe_cnt <= strobe_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    vif.serial_in = b;
    last_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle_bits(input int n, input logic b);
    repeat (n) send_bit(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vif.serial_in = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(3, 1'b0);
  endtask

  task automatic lock_link();
    repeat (4) send_byte(BC);
  endtask

  task automatic test_reset();
    int base;
    @(negedge clk);
    vif.serial_in = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (vif.data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", vif.data_out); end
    n_cmp++; if (vif.valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", vif.valid_out); end
    n_cmp++; if (vif.byte_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", vif.byte_strobe); end
    n_cmp++; if (vif.active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", vif.active); end
    n_cmp++; if (vif.idle_out !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", vif.idle_out); end
    rst_n = 1'b1;
    base = strobe_cnt;
    idle_bits(40, 1'b0);
    n_cmp++; if (vif.active !== 1'b0) begin n_bad++; $display("FAIL stuck0_active: got %b want 0", vif.active); end
    n_cmp++; if (vif.idle_out !== 1'b1) begin n_bad++; $display("FAIL stuck0_idle: got %b want 1", vif.idle_out); end
    idle_bits(40, 1'b1);
    n_cmp++; if (vif.active !== 1'b0) begin n_bad++; $display("FAIL stuck1_active: got %b want 0", vif.active); end
    n_cmp++; if (vif.idle_out !== 1'b1) begin n_bad++; $display("FAIL stuck1_idle: got %b want 1", vif.idle_out); end
    n_cmp++; if (strobe_cnt !== base) begin n_bad++; $display("FAIL stuck_strobes: got %0d want 0", strobe_cnt - base); end
  endtask

  task automatic test_lock();
    int base, d, da;
    do_reset();
    base = strobe_cnt;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    lock_link();
    d = last_cyc;
    n_cmp++; if (vif.active !== 1'b0) begin n_bad++; $display("FAIL lock_early_active: got %b want 0", vif.active); end
    send_byte(8'hA5);
    da = last_cyc;
    idle_bits(4, 1'b0);
    n_cmp++; if (act_cyc !== d + 2) begin n_bad++; $display("FAIL lock_active_cyc: got %0d want %0d", act_cyc, d + 2); end
    n_cmp++; if (strobe_cnt - base !== 1) begin n_bad++; $display("FAIL lock_strobe_count: got %0d want 1", strobe_cnt - base); end
    n_cmp++; if (recs[base % 256].data !== 8'hA5) begin n_bad++; $display("FAIL lock_data: got %h want a5", recs[base % 256].data); end
    n_cmp++; if (recs[base % 256].valid !== 1'b1) begin n_bad++; $display("FAIL lock_valid: got %b want 1", recs[base % 256].valid); end
    n_cmp++; if (recs[base % 256].cyc !== da + 2) begin n_bad++; $display("FAIL lock_data_cyc: got %0d want %0d", recs[base % 256].cyc, da + 2); end
  endtask

  task automatic test_sync_abort();
    int base, d, da;
    do_reset();
    base = strobe_cnt;
    send_byte(BC); send_byte(BC); send_byte(8'h12);
    lock_link();
    d = last_cyc;
    send_byte(8'h3C);
    da = last_cyc;
    idle_bits(4, 1'b0);
    n_cmp++; if (act_cyc !== d + 2) begin n_bad++; $display("FAIL abort_active_cyc: got %0d want %0d", act_cyc, d + 2); end
    n_cmp++; if (strobe_cnt - base !== 1) begin n_bad++; $display("FAIL abort_strobe_count: got %0d want 1", strobe_cnt - base); end
    n_cmp++; if (recs[base % 256].data !== 8'h3C) begin n_bad++; $display("FAIL abort_data: got %h want 3c", recs[base % 256].data); end
    n_cmp++; if (recs[base % 256].valid !== 1'b1) begin n_bad++; $display("FAIL abort_valid: got %b want 1", recs[base % 256].valid); end
    n_cmp++; if (recs[base % 256].cyc !== da + 2) begin n_bad++; $display("FAIL abort_data_cyc: got %0d want %0d", recs[base % 256].cyc, da + 2); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    logic       exp_v [5];
    logic       exp_i [5];
    int         lc    [5];
    int         base;
    rec_t       r;
    // 0x0B,0xC0 carries a COM pattern straddling the boundary; it must pass through as data.
    bytes = '{8'h01, 8'hBC, 8'hFF, 8'h0B, 8'hC0};
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_i = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    lock_link();
    base = strobe_cnt;
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i]);
      lc[i] = last_cyc;
    end
    idle_bits(4, 1'b0);
    n_cmp++; if (strobe_cnt - base !== 5) begin n_bad++; $display("FAIL stream_count: got %0d want 5", strobe_cnt - base); end
    for (int i = 0; i < 5; i++) begin
      r = recs[(base + i) % 256];
      n_cmp++; if (r.data !== bytes[i]) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, r.data, bytes[i]); end
      n_cmp++; if (r.valid !== exp_v[i]) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want %b", i, r.valid, exp_v[i]); end
      n_cmp++; if (r.idle !== exp_i[i]) begin n_bad++; $display("FAIL stream_idle[%0d]: got %b want %b", i, r.idle, exp_i[i]); end
      n_cmp++; if (r.cyc !== lc[i] + 2) begin n_bad++; $display("FAIL stream_cyc[%0d]: got %0d want %0d", i, r.cyc, lc[i] + 2); end
    end
  endtask

  task automatic test_reset_midbyte();
    int d;
    do_reset();
    lock_link();
    send_byte(8'h5A);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    n_cmp++; if (vif.data_out !== 8'h5A) begin n_bad++; $display("FAIL pre_reset_data: got %h want 5a", vif.data_out); end
    #2;
    rst_n = 1'b0;
    vif.serial_in = 1'b0;
    #1;
    n_cmp++; if (vif.data_out !== 8'h00) begin n_bad++; $display("FAIL async_data: got %h want 00", vif.data_out); end
    n_cmp++; if (vif.valid_out !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b want 0", vif.valid_out); end
    n_cmp++; if (vif.active !== 1'b0) begin n_bad++; $display("FAIL async_active: got %b want 0", vif.active); end
    n_cmp++; if (vif.idle_out !== 1'b1) begin n_bad++; $display("FAIL async_idle: got %b want 1", vif.idle_out); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) send_byte(BC);
    send_byte(BC);
    d = last_cyc;
    n_cmp++; if (vif.active !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %b want 0", vif.active); end
    idle_bits(3, 1'b0);
    n_cmp++; if (act_cyc !== d + 2) begin n_bad++; $display("FAIL relock_cyc: got %0d want %0d", act_cyc, d + 2); end
    n_cmp++; if (vif.active !== 1'b1) begin n_bad++; $display("FAIL relock_active: got %b want 1", vif.active); end
  endtask

`ifdef SERIAL_PARALELO_BYTE_CNT_EN
  task automatic test_byte_cnt();
    do_reset();
    n_cmp++; if (vif.byte_cnt !== 16'd0) begin n_bad++; $display("FAIL byte_cnt_reset: got %0d want 0", vif.byte_cnt); end
    lock_link();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(BC); send_byte(BC);
    idle_bits(4, 1'b0);
    n_cmp++; if (vif.byte_cnt !== 16'd3) begin n_bad++; $display("FAIL byte_cnt: got %0d want 3", vif.byte_cnt); end
  endtask
`endif

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    cyc        = 0;
    strobe_cnt = 0;
    act_cyc    = -1;
    last_cyc   = 0;
    rst_n      = 1'b0;
    vif.serial_in = 1'b0;
    test_reset();
    test_lock();
    test_sync_abort();
    test_back_to_back();
    test_reset_midbyte();
`ifdef SERIAL_PARALELO_BYTE_CNT_EN
    test_byte_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_alineador.md
Name: serial_paralelo_alineador

Overview:
Receive-side deserializer and byte aligner for the PHY link, directly downstream of the transmitter's parallel-to-serial stage.
- Samples the 1-bit serial stream on clk_32f and hunts for the 0xBC comma at any bit offset.
- Locks the byte boundary after consecutive commas, then delivers bytes with a valid flag toward the RX demux path.
- Single-clock design; all byte timing is derived from an internal bit counter.

Parameters:
COM, 8'hBC, comma/idle byte used for alignment and idle detection
BC_LOCK, 4, number of consecutive boundary-aligned COM bytes required to declare lock (range 1..15)

Ports:
clk_32f  input  1  bit clock; one serial bit sampled per rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
serial_in  input  1  serial data, MSB first, driven by upstream paralelo_serial output
data_out  output  8  last aligned byte; held 8 cycles between updates
valid_out  output  1  1 = data_out is a non-COM data byte while locked; held with data_out
byte_strobe  output  1  1-cycle pulse on each data_out/valid_out update
active  output  1  lock indication; sticky until reset
idle_out  output  1  1 when not locked, or when locked and the current byte is COM

Behaviour:
Reset (async assert, sync release):
- sr=0, bit_cnt=0, bc_cnt=0, state=SEARCH.
- Outputs: data_out=8'h00, valid_out=0, byte_strobe=0, active=0, idle_out=1.

Shifting and boundaries:
- Every edge: sr <= {sr[6:0], serial_in}.
- bit_cnt is a 3-bit counter, wrapping 7->0.
- A byte boundary is the edge where bit_cnt==7 while state!=SEARCH. At that edge sr holds the completed byte (comparisons use sr before the shift).

State machine: SEARCH, SYNC, LOCKED.

SEARCH:
- Checked on every edge: if sr==COM, then bit_cnt<=0, bc_cnt<=1, and the next boundary falls 8 edges later. State goes to SYNC, or directly to LOCKED if BC_LOCK==1.
- Otherwise stay in SEARCH.
- data_out is not updated; byte_strobe=0.

SYNC, at each boundary:
- sr==COM: bc_cnt++. When bc_cnt reaches BC_LOCK, go to LOCKED and set active<=1 at that edge.
- sr!=COM: go to SEARCH, bc_cnt<=0. A COM ending at this same edge at a new offset is not detected until the next SEARCH edge.

LOCKED, at each boundary:
- data_out<=sr, byte_strobe<=1 for one cycle.
- valid_out<=(sr!=COM), idle_out<=(sr==COM).
- Lock is never dropped except by reset. Misaligned data is passed through as-is.

Latency and widths:
- data_out updates one edge after the edge sampling the byte's last bit.
- First output byte is the byte following the BC_LOCK-th comma.
- bc_cnt is 4 bits and saturates at BC_LOCK.

Boundary conditions:
- Reset mid-byte discards the partial byte and all outputs immediately; realignment restarts from SEARCH.
- COM bit patterns straddling byte boundaries while LOCKED are ignored.
- Serial stuck at 0 or 1: remains in SEARCH indefinitely with idle_out=1.

Optional Feature:
SERIAL_PARALELO_BYTE_CNT_EN
- Defined: adds output byte_cnt[15:0], the count of bytes delivered with valid_out=1. It increments on the same edge valid_out is set, wraps 16'hFFFF->0, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset held low 5 cycles, then released with serial_in=0 -> all outputs at reset values; state stays SEARCH; idle_out=1.
2. Three garbage bits 101, then BC,BC,BC,BC,0xA5 MSB-first -> active=1 at the 4th BC's boundary+1 edge; data_out=0xA5, valid_out=1 eight edges later; byte_strobe pulses once.
3. BC,BC,0x12,BC,BC,BC,BC,0x3C -> SYNC aborts at 0x12 and returns to SEARCH; relock on the later BCs; data_out=0x3C, valid_out=1; 0x12 never output.
4. After lock, stream 0x01,BC,0xFF -> valid_out sequence 1,0,1; idle_out 0,1,0; data_out 0x01,0xBC,0xFF at 8-cycle spacing.
5. After lock, reset pulsed low for 1 cycle mid-byte -> outputs return to reset values asynchronously; 4 new BCs are required before active=1 again.
6. With SERIAL_PARALELO_BYTE_CNT_EN defined: lock, then 3 data bytes and 2 BCs -> byte_cnt=3; with preset 16'hFFFF plus 1 data byte -> byte_cnt=0.
